// File: rtl/csr_exec_unit.sv
// Zicsr read-modify-write sequencer: reads a CSR, computes RW/RS/RC result, writes it
// back to csr_file and returns the old value for rd. One instruction in flight at a time.
module csr_exec_unit #(
  parameter int XLEN        = 64,
  parameter bit RO_CHECK_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush_i,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [1:0]      req_op_i,
  input  logic [11:0]     req_csr_i,
  input  logic [XLEN-1:0] req_src_i,
  input  logic            req_src_zero_i,
  input  logic [4:0]      req_rd_i,
  output logic [11:0]     csr_raddr_o,
  input  logic [XLEN-1:0] csr_rdata_i,
  output logic [11:0]     csr_waddr_o,
  output logic [XLEN-1:0] csr_wdata_o,
  output logic            csr_we_o,
  output logic            resp_valid_o,
  input  logic            resp_ready_i,
  output logic [4:0]      resp_rd_o,
  output logic [XLEN-1:0] resp_data_o,
  output logic            resp_illegal_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t          r_state;
  logic [1:0]      r_op;
  logic [11:0]     r_csr;
  logic [XLEN-1:0] r_src;
  logic            r_src_zero;
  logic [4:0]      r_rd;
  logic [11:0]     r_raddr;
  logic [XLEN-1:0] r_new;
  logic [XLEN-1:0] r_old;
  logic            r_do_wr;
  logic            r_illegal;

  logic [XLEN-1:0] w_new_val;
  logic            w_wr_intent;
  logic            w_illegal;
  logic            w_do_wr;

  // New CSR value and legality, evaluated against the live read data during READ
  always_comb begin
    w_new_val = '0;
    case (r_op)
      2'b01:   w_new_val = r_src;
      2'b10:   w_new_val = csr_rdata_i | r_src;
      2'b11:   w_new_val = csr_rdata_i & ~r_src;
      default: w_new_val = '0;
    endcase
    w_wr_intent = (r_op == 2'b01) || !r_src_zero;
    w_illegal   = (r_op == 2'b00) ||
                  (RO_CHECK_EN && w_wr_intent && (r_csr[11:10] == 2'b11));
    w_do_wr     = w_wr_intent && !w_illegal;
  end

  // Sequencer: IDLE -> READ -> WRITE -> RESP, any flush returns to IDLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_op       <= 2'b00;
      r_csr      <= 12'h000;
      r_src      <= '0;
      r_src_zero <= 1'b0;
      r_rd       <= 5'd0;
      r_raddr    <= 12'h000;
      r_new      <= '0;
      r_old      <= '0;
      r_do_wr    <= 1'b0;
      r_illegal  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid_i && !flush_i) begin
            r_op       <= req_op_i;
            r_csr      <= req_csr_i;
            r_raddr    <= req_csr_i;
            r_src      <= req_src_i;
            r_src_zero <= req_src_zero_i;
            r_rd       <= req_rd_i;
            r_state    <= S_READ;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_READ: begin
          if (flush_i) begin
            r_state <= S_IDLE;
          end else begin
            r_new     <= w_new_val;
            r_old     <= w_illegal ? '0 : csr_rdata_i;
            r_do_wr   <= w_do_wr;
            r_illegal <= w_illegal;
            r_state   <= S_WRITE;
          end
        end
        S_WRITE: begin
          r_state <= flush_i ? S_IDLE : S_RESP;
        end
        S_RESP: begin
          if (flush_i || resp_ready_i) begin
            r_state <= S_IDLE;
          end else begin
            r_state <= S_RESP;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Write enable is gated by flush in the same cycle so an aborted op never commits
  assign csr_we_o       = (r_state == S_WRITE) && r_do_wr && !flush_i;
  assign req_ready_o    = (r_state == S_IDLE) && !flush_i;
  assign resp_valid_o   = (r_state == S_RESP);
  assign csr_raddr_o    = r_raddr;
  assign csr_waddr_o    = r_csr;
  assign csr_wdata_o    = r_new;
  assign resp_rd_o      = r_rd;
  assign resp_data_o    = r_old;
  assign resp_illegal_o = r_illegal;

endmodule

// File: tb/tb_csr_exec_unit.sv
// Directed bench for csr_exec_unit with a small behavioural csr_file model
// (16-entry storage plus a free-running cycle counter at 0xC00).
module tb_csr_exec_unit;
  localparam int XLEN = 64;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            flush_i = 1'b0;
  logic            req_valid_i = 1'b0;
  logic            req_ready_o;
  logic [1:0]      req_op_i = 2'b00;
  logic [11:0]     req_csr_i = 12'h000;
  logic [XLEN-1:0] req_src_i = '0;
  logic            req_src_zero_i = 1'b0;
  logic [4:0]      req_rd_i = 5'd0;
  logic [11:0]     csr_raddr_o;
  logic [XLEN-1:0] csr_rdata_i;
  logic [11:0]     csr_waddr_o;
  logic [XLEN-1:0] csr_wdata_o;
  logic            csr_we_o;
  logic            resp_valid_o;
  logic            resp_ready_i = 1'b1;
  logic [4:0]      resp_rd_o;
  logic [XLEN-1:0] resp_data_o;
  logic            resp_illegal_o;

  int checks = 0;
  int errors = 0;

  logic [XLEN-1:0] mem [0:15];
  logic [XLEN-1:0] cyc = '0;
  logic            mon_en = 1'b0;
  logic            saw_we = 1'b0;

  csr_exec_unit #(.XLEN(XLEN), .RO_CHECK_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_op_i(req_op_i),
    .req_csr_i(req_csr_i), .req_src_i(req_src_i), .req_src_zero_i(req_src_zero_i),
    .req_rd_i(req_rd_i), .csr_raddr_o(csr_raddr_o), .csr_rdata_i(csr_rdata_i),
    .csr_waddr_o(csr_waddr_o), .csr_wdata_o(csr_wdata_o), .csr_we_o(csr_we_o),
    .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i), .resp_rd_o(resp_rd_o),
    .resp_data_o(resp_data_o), .resp_illegal_o(resp_illegal_o)
  );

  always #5 clk = ~clk;

  // csr_file model: combinational read, registered write, cycle counter at 0xC00
  always_comb begin
    if (csr_raddr_o == 12'hC00) csr_rdata_i = cyc;
    else                        csr_rdata_i = mem[csr_raddr_o[3:0]];
  end

  always @(posedge clk) begin
    cyc <= cyc + 64'd1;
    if (csr_we_o && csr_waddr_o[11:4] == 8'h00) mem[csr_waddr_o[3:0]] <= csr_wdata_o;
  end

  always @(negedge clk) if (mon_en && csr_we_o) saw_we = 1'b1;

  task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic drive_req(input logic [1:0] op, input logic [11:0] csr,
                           input logic [XLEN-1:0] src, input logic zero, input logic [4:0] rd);
    req_valid_i = 1'b1; req_op_i = op; req_csr_i = csr;
    req_src_i = src; req_src_zero_i = zero; req_rd_i = rd;
  endtask

  // Full op with resp_ready high; exp_data < 0 style handled by use_cyc (counter sampled in READ)
  task automatic run_op(input string tag, input logic [1:0] op, input logic [11:0] csr,
                        input logic [XLEN-1:0] src, input logic zero, input logic [4:0] rd,
                        input logic exp_we, input logic [XLEN-1:0] exp_wdata,
                        input logic [XLEN-1:0] exp_data, input logic exp_ill, input logic use_cyc);
    logic [XLEN-1:0] want;
    want = exp_data;
    drive_req(op, csr, src, zero, rd);
    chk({tag, ".ready"}, {63'd0, req_ready_o}, 64'd1);
    tick();
    req_valid_i = 1'b0;
    if (use_cyc) want = cyc;
    chk({tag, ".raddr"}, {52'd0, csr_raddr_o}, {52'd0, csr});
    chk({tag, ".we_read"}, {63'd0, csr_we_o}, 64'd0);
    tick();
    chk({tag, ".we"}, {63'd0, csr_we_o}, {63'd0, exp_we});
    if (exp_we) begin
      chk({tag, ".wdata"}, csr_wdata_o, exp_wdata);
      chk({tag, ".waddr"}, {52'd0, csr_waddr_o}, {52'd0, csr});
    end
    tick();
    chk({tag, ".valid"}, {63'd0, resp_valid_o}, 64'd1);
    chk({tag, ".data"}, resp_data_o, want);
    chk({tag, ".rd"}, {59'd0, resp_rd_o}, {59'd0, rd});
    chk({tag, ".ill"}, {63'd0, resp_illegal_o}, {63'd0, exp_ill});
    chk({tag, ".we_resp"}, {63'd0, csr_we_o}, 64'd0);
    tick();
    chk({tag, ".idle"}, {63'd0, resp_valid_o}, 64'd0);
  endtask

  initial begin
    logic [XLEN-1:0] hold_data;
    for (int i = 0; i < 16; i++) mem[i] = 64'd0;
    mem[5] = 64'h11;
    mem[3] = 64'hF0;
    mem[7] = 64'h77;

    // Reset state
    #12;
    chk("rst.ready", {63'd0, req_ready_o}, 64'd0 | 64'd1);
    chk("rst.valid", {63'd0, resp_valid_o}, 64'd0);
    chk("rst.we", {63'd0, csr_we_o}, 64'd0);
    chk("rst.raddr", {52'd0, csr_raddr_o}, 64'd0);
    chk("rst.data", resp_data_o, 64'd0);
    @(negedge clk); rst_n = 1'b1;
    tick();

    // 1: CSRRW then re-read
    run_op("rw5", 2'b01, 12'h005, 64'hAA, 1'b0, 5'd1, 1'b1, 64'hAA, 64'h11, 1'b0, 1'b0);
    run_op("rd5", 2'b10, 12'h005, 64'h0, 1'b1, 5'd2, 1'b0, 64'h0, 64'hAA, 1'b0, 1'b0);
    chk("mem5", mem[5], 64'hAA);

    // 2: set and clear
    run_op("rs3", 2'b10, 12'h003, 64'h0F, 1'b0, 5'd3, 1'b1, 64'hFF, 64'hF0, 1'b0, 1'b0);
    run_op("rc3", 2'b11, 12'h003, 64'h0F, 1'b0, 5'd4, 1'b1, 64'hF0, 64'hFF, 1'b0, 1'b0);

    // 3: counter read legal, counter write illegal, op 00 illegal
    run_op("rscyc", 2'b10, 12'hC00, 64'h0, 1'b1, 5'd5, 1'b0, 64'h0, 64'h0, 1'b0, 1'b1);
    run_op("rwcyc", 2'b01, 12'hC00, 64'h5, 1'b0, 5'd6, 1'b0, 64'h0, 64'h0, 1'b1, 1'b0);
    run_op("op00", 2'b00, 12'h003, 64'h5, 1'b0, 5'd7, 1'b0, 64'h0, 64'h0, 1'b1, 1'b0);

    // 4: backpressure for 5 cycles, next request waiting during handshake
    resp_ready_i = 1'b0;
    drive_req(2'b10, 12'h007, 64'h100, 1'b0, 5'd9);
    tick(); req_valid_i = 1'b0;
    tick(); tick();
    for (int i = 0; i < 5; i++) begin
      chk("bp.valid", {63'd0, resp_valid_o}, 64'd1);
      chk("bp.data", resp_data_o, 64'h77);
      chk("bp.rd", {59'd0, resp_rd_o}, 64'd9);
      chk("bp.ready", {63'd0, req_ready_o}, 64'd0);
      tick();
    end
    resp_ready_i = 1'b1;
    drive_req(2'b10, 12'h007, 64'h0, 1'b1, 5'd10);
    tick();
    chk("bp.after_valid", {63'd0, resp_valid_o}, 64'd0);
    chk("bp.after_ready", {63'd0, req_ready_o}, 64'd1);
    tick(); req_valid_i = 1'b0;
    chk("bp.next_raddr", {52'd0, csr_raddr_o}, 64'h7);
    tick(); tick();
    chk("bp.next_data", resp_data_o, 64'h177);
    chk("bp.next_rd", {59'd0, resp_rd_o}, 64'd10);
    tick();

    // 5a: flush in READ
    mon_en = 1'b1; saw_we = 1'b0;
    drive_req(2'b01, 12'h003, 64'hDEAD, 1'b0, 5'd11);
    tick(); req_valid_i = 1'b0; flush_i = 1'b1;
    #1 chk("flr.ready_blocked", {63'd0, req_ready_o}, 64'd0);
    tick(); flush_i = 1'b0;
    #1 chk("flr.ready", {63'd0, req_ready_o}, 64'd1);
    chk("flr.valid", {63'd0, resp_valid_o}, 64'd0);
    tick(); tick();
    chk("flr.valid2", {63'd0, resp_valid_o}, 64'd0);
    // 5b: flush in WRITE
    drive_req(2'b01, 12'h003, 64'hBEEF, 1'b0, 5'd12);
    tick(); req_valid_i = 1'b0;
    tick(); flush_i = 1'b1;
    #1 chk("flw.we", {63'd0, csr_we_o}, 64'd0);
    tick(); flush_i = 1'b0;
    #1 chk("flw.ready", {63'd0, req_ready_o}, 64'd1);
    tick(); tick();
    chk("flw.valid", {63'd0, resp_valid_o}, 64'd0);
    chk("fl.saw_we", {63'd0, saw_we}, 64'd0);
    chk("fl.mem3", mem[3], 64'hF0);
    mon_en = 1'b0;

    // 6: async reset during WRITE
    drive_req(2'b01, 12'h005, 64'h55, 1'b0, 5'd13);
    tick(); req_valid_i = 1'b0;
    tick();
    chk("rstw.we_before", {63'd0, csr_we_o}, 64'd1);
    rst_n = 1'b0;
    #1 chk("rstw.we", {63'd0, csr_we_o}, 64'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("rstw.valid", {63'd0, resp_valid_o}, 64'd0);
    chk("rstw.ready", {63'd0, req_ready_o}, 64'd1);
    chk("rstw.mem5", mem[5], 64'hAA);
    hold_data = resp_data_o;
    chk("rstw.data", hold_data, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
